axis_pkt_arbiter: RTL and testbench
===================================

AXIS_PKT_ARBITER -- requirements
Module: axis_pkt_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 512, tdata width.
REQ-002 SHALL have parameter KEEP_W, default DATA_W/8, tkeep width.
REQ-003 SHALL have parameter USER_W, default 137, tuser width.
REQ-004 SHALL have parameter CNT_W, default 32, packet-counter width.
REQ-005 SHALL use one clock; reset is asynchronous and active-high; ports named CLK and RST.
REQ-006 Ports: CLK  in  1  clock; RST  in  1  async active-high reset.
REQ-007 Ports: s00_axis_tdata/tkeep/tuser/tlast/tvalid  in  DATA_W/KEEP_W/USER_W/1/1  requester 0 stream; s00_axis_tready  out  1.
REQ-008 Ports: s01_axis_* identical to s00, requester 1.
REQ-009 Ports: m00_axis_tdata/tkeep/tuser/tlast/tvalid  out  DATA_W/KEEP_W/USER_W/1/1  merged stream; m00_axis_tready  in  1.
REQ-010 Ports: grant  out  2  one-hot current owner (bit0 = s00, bit1 = s01), 00 when idle.
REQ-011 Ports: pkt_cnt0, pkt_cnt1  out  CNT_W  packets forwarded per requester.

Function
REQ-012 SHALL arbitrate on packet boundaries only; once granted, a requester owns the output until its tlast beat is accepted.
REQ-013 FSM states IDLE, OWN0, OWN1; IDLE->OWNx when s0x tvalid and x wins arbitration; OWNx->IDLE on accepted input beat with tlast=1.
REQ-014 Arbitration SHALL be round-robin: last_served flag (reset = 1, so s00 wins first); if both valid, the port not last served wins; if one valid, it wins.
REQ-015 Arbitration decision SHALL take one cycle in IDLE (no beat accepted in the IDLE cycle); back-to-back packets thus incur one bubble.
REQ-016 Output SHALL be a single registered stage: out_valid flag plus data/keep/user/last registers.
REQ-017 s0x_axis_tready SHALL be combinational: 1 only in OWNx and (out_valid=0 or m00_axis_tready=1); non-owner tready SHALL be 0.
REQ-018 Input beat accepted when owner tvalid and tready both 1; it loads the output register, out_valid=1 next cycle.
REQ-019 out_valid SHALL clear when m00_axis_tready=1 and no new beat is loaded that cycle; m00 outputs SHALL hold stable while tvalid=1 and tready=0.
REQ-020 Latency: accepted input beat appears on m00 the following cycle; full throughput of one beat/cycle within a packet with m00_axis_tready held high.
REQ-021 pkt_cntx SHALL increment by 1 when a s0x tlast beat is accepted; wraps modulo 2^CNT_W with no saturation.
REQ-022 Single-beat packet (tvalid and tlast on first beat) SHALL return to IDLE after one accepted beat.
REQ-023 Non-owner tvalid SHALL never affect output or state; its data is never dropped (tready held 0).
REQ-024 grant SHALL reflect the FSM state directly (registered).

Reset
REQ-025 On RST=1 asynchronously: state=IDLE, last_served=1, out_valid=0, m00 tdata/tkeep/tuser/tlast=0, grant=00, pkt_cnt0=pkt_cnt1=0.
REQ-026 Reset mid-packet SHALL abandon the packet; no partial-packet recovery; after RST deasserts, arbitration restarts with s00 priority.
REQ-027 All s0x tready and m00_axis_tvalid SHALL be 0 while RST=1.

Structure
REQ-028 Shared package axis_arb_pkg SHALL hold the FSM state enum (IDLE, OWN0, OWN1) and default width constants (512, 64, 137, 32).
REQ-029 Output register stage SHALL be a sub-module axis_out_reg (load, tready-in, valid/data out), instantiated once.

Verification
REQ-030 Both ports present 3-beat packets simultaneously after reset, m00 tready=1 -> s00 packet (3 beats) then 1 bubble then s01 packet; grant 01 then 10; pkt_cnt0=1, pkt_cnt1=1.
REQ-031 s01 continuously valid with 2-beat packets, s00 idle -> s01 served every packet, one bubble between packets, pkt_cnt1 increments per tlast.
REQ-032 Mid-packet m00 tready=0 for 4 cycles -> m00 data/tvalid stable, s00 tready=0, no beat lost or duplicated (compare sequence 0x1..0x5).
REQ-033 s00 single-beat packets while s01 asserts valid -> strict alternation s00, s01, s00 ...; s01 tready=0 while s00 owns.
REQ-034 Assert RST for 1 cycle during beat 2 of a 4-beat s01 packet -> all outputs 0 immediately, counters 0, next grant goes to s00 if both valid.
REQ-035 Preload pkt_cnt0 near 2^CNT_W-1 (CNT_W=4 build), send 2 packets -> counter wraps 15->0->1.

Source files
------------

// File: rtl/axis_arb_pkg.sv
// -----------------------------------------------------------------------------
// axis_arb_pkg
// Shared definitions for the two-input AXI-Stream packet arbiter:
//   - arb_state_t : arbiter FSM states (IDLE, OWN0, OWN1)
//   - DEF_*       : default widths for data, keep, user and packet counters
//   - state_to_grant : maps an FSM state onto the one-hot grant vector
// -----------------------------------------------------------------------------
package axis_arb_pkg;

  localparam int DEF_DATA_W = 512;
  localparam int DEF_KEEP_W = 64;
  localparam int DEF_USER_W = 137;
  localparam int DEF_CNT_W  = 32;

  // Encoding chosen so that the owner state is already the one-hot grant.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } arb_state_t;

  function automatic logic [1:0] state_to_grant(input arb_state_t st);
    logic [1:0] g;
    case (st)
      OWN0:    g = 2'b01;
      OWN1:    g = 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// -----------------------------------------------------------------------------
// axis_out_reg
// Single registered AXI-Stream output stage.
// Ports:
//   CLK, RST                 clock, async active-high reset
//   load                     capture in_* this cycle (a beat was accepted)
//   in_data/keep/user/last   beat to capture
//   in_ready                 stage can take a beat (empty, or draining now)
//   out_tready               downstream ready
//   out_valid/data/keep/user/last  registered output beat
// -----------------------------------------------------------------------------
module axis_out_reg #(
  parameter int DATA_W = 512,
  parameter int KEEP_W = 64,
  parameter int USER_W = 137
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              load,
  input  logic [DATA_W-1:0] in_data,
  input  logic [KEEP_W-1:0] in_keep,
  input  logic [USER_W-1:0] in_user,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              out_tready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [KEEP_W-1:0] out_keep,
  output logic [USER_W-1:0] out_user,
  output logic              out_last
);

  logic              valid_r;
  logic [DATA_W-1:0] data_r;
  logic [KEEP_W-1:0] keep_r;
  logic [USER_W-1:0] user_r;
  logic              last_r;

  // The stage may take a new beat when empty or when its current beat leaves now.
  assign in_ready = (~valid_r) | out_tready;

  // Output register: payload only changes on load, so it holds while stalled.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_r <= 1'b0;
      data_r  <= {DATA_W{1'b0}};
      keep_r  <= {KEEP_W{1'b0}};
      user_r  <= {USER_W{1'b0}};
      last_r  <= 1'b0;
    end else if (load) begin
      valid_r <= 1'b1;
      data_r  <= in_data;
      keep_r  <= in_keep;
      user_r  <= in_user;
      last_r  <= in_last;
    end else if (out_tready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign out_valid = valid_r;
  assign out_data  = data_r;
  assign out_keep  = keep_r;
  assign out_user  = user_r;
  assign out_last  = last_r;

endmodule

// File: rtl/axis_pkt_arbiter.sv
// -----------------------------------------------------------------------------
// axis_pkt_arbiter
// Two-input AXI-Stream arbiter that switches only on packet boundaries, using
// round-robin between s00 and s01, into one registered m00 output stage.
// Ports:
//   CLK, RST                       clock, async active-high reset
//   s00_axis_*, s01_axis_*         requester streams (tdata/tkeep/tuser/tlast/
//                                  tvalid in, tready out)
//   m00_axis_*                     merged stream (tready in)
//   grant                          one-hot current owner, 00 when idle
//   pkt_cnt0, pkt_cnt1             packets forwarded per requester (wrapping)
// -----------------------------------------------------------------------------
module axis_pkt_arbiter
  import axis_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int KEEP_W = DATA_W / 8,
  parameter int USER_W = DEF_USER_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] s00_axis_tdata,
  input  logic [KEEP_W-1:0] s00_axis_tkeep,
  input  logic [USER_W-1:0] s00_axis_tuser,
  input  logic              s00_axis_tlast,
  input  logic              s00_axis_tvalid,
  output logic              s00_axis_tready,
  input  logic [DATA_W-1:0] s01_axis_tdata,
  input  logic [KEEP_W-1:0] s01_axis_tkeep,
  input  logic [USER_W-1:0] s01_axis_tuser,
  input  logic              s01_axis_tlast,
  input  logic              s01_axis_tvalid,
  output logic              s01_axis_tready,
  output logic [DATA_W-1:0] m00_axis_tdata,
  output logic [KEEP_W-1:0] m00_axis_tkeep,
  output logic [USER_W-1:0] m00_axis_tuser,
  output logic              m00_axis_tlast,
  output logic              m00_axis_tvalid,
  input  logic              m00_axis_tready,
  output logic [1:0]        grant,
  output logic [CNT_W-1:0]  pkt_cnt0,
  output logic [CNT_W-1:0]  pkt_cnt1
);

  arb_state_t        state_r;
  arb_state_t        state_nx_s;
  logic              last_served_r;   // 1: s01 was served last, so s00 wins a tie
  logic              out_ready_s;
  logic              acc0_s;
  logic              acc1_s;
  logic              load_s;
  logic [DATA_W-1:0] sel_data_s;
  logic [KEEP_W-1:0] sel_keep_s;
  logic [USER_W-1:0] sel_user_s;
  logic              sel_last_s;
  logic [CNT_W-1:0]  pkt_cnt0_r;
  logic [CNT_W-1:0]  pkt_cnt1_r;

  // Only the owner sees ready; IDLE (including during reset) gives nobody ready.
  assign s00_axis_tready = (state_r == OWN0) & out_ready_s;
  assign s01_axis_tready = (state_r == OWN1) & out_ready_s;
  assign acc0_s          = s00_axis_tvalid & s00_axis_tready;
  assign acc1_s          = s01_axis_tvalid & s01_axis_tready;
  assign load_s          = acc0_s | acc1_s;

  // Next-state: round-robin pick in IDLE, release ownership on accepted tlast.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (s00_axis_tvalid && s01_axis_tvalid) begin
          if (last_served_r) begin
            state_nx_s = OWN0;
          end else begin
            state_nx_s = OWN1;
          end
        end else if (s00_axis_tvalid) begin
          state_nx_s = OWN0;
        end else if (s01_axis_tvalid) begin
          state_nx_s = OWN1;
        end else begin
          state_nx_s = IDLE;
        end
      end
      OWN0: begin
        if (acc0_s && s00_axis_tlast) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = OWN0;
        end
      end
      OWN1: begin
        if (acc1_s && s01_axis_tlast) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = OWN1;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State register and round-robin history, updated when a grant is issued.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r       <= IDLE;
      last_served_r <= 1'b1;
    end else begin
      state_r <= state_nx_s;
      if (state_r == IDLE && state_nx_s == OWN0) begin
        last_served_r <= 1'b0;
      end else if (state_r == IDLE && state_nx_s == OWN1) begin
        last_served_r <= 1'b1;
      end else begin
        last_served_r <= last_served_r;
      end
    end
  end

  // Payload mux: the owner's stream feeds the output stage.
  always_comb begin
    sel_data_s = s00_axis_tdata;
    sel_keep_s = s00_axis_tkeep;
    sel_user_s = s00_axis_tuser;
    sel_last_s = s00_axis_tlast;
    if (state_r == OWN1) begin
      sel_data_s = s01_axis_tdata;
      sel_keep_s = s01_axis_tkeep;
      sel_user_s = s01_axis_tuser;
      sel_last_s = s01_axis_tlast;
    end else begin
      sel_data_s = s00_axis_tdata;
      sel_keep_s = s00_axis_tkeep;
      sel_user_s = s00_axis_tuser;
      sel_last_s = s00_axis_tlast;
    end
  end

  // Per-requester packet counters, wrapping on overflow.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pkt_cnt0_r <= {CNT_W{1'b0}};
      pkt_cnt1_r <= {CNT_W{1'b0}};
    end else begin
      if (acc0_s && s00_axis_tlast) begin
        pkt_cnt0_r <= pkt_cnt0_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        pkt_cnt0_r <= pkt_cnt0_r;
      end
      if (acc1_s && s01_axis_tlast) begin
        pkt_cnt1_r <= pkt_cnt1_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        pkt_cnt1_r <= pkt_cnt1_r;
      end
    end
  end

  axis_out_reg #(
    .DATA_W (DATA_W),
    .KEEP_W (KEEP_W),
    .USER_W (USER_W)
  ) u_out_reg (
    .CLK        (CLK),
    .RST        (RST),
    .load       (load_s),
    .in_data    (sel_data_s),
    .in_keep    (sel_keep_s),
    .in_user    (sel_user_s),
    .in_last    (sel_last_s),
    .in_ready   (out_ready_s),
    .out_tready (m00_axis_tready),
    .out_valid  (m00_axis_tvalid),
    .out_data   (m00_axis_tdata),
    .out_keep   (m00_axis_tkeep),
    .out_user   (m00_axis_tuser),
    .out_last   (m00_axis_tlast)
  );

  assign grant    = state_to_grant(state_r);
  assign pkt_cnt0 = pkt_cnt0_r;
  assign pkt_cnt1 = pkt_cnt1_r;

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axis_pkt_arbiter
// Self-checking bench for axis_pkt_arbiter (narrow build, 4-bit counters).
// Input beats come from per-port queues; the expected m00 beat order is pushed
// to a scoreboard queue and popped on every m00 handshake.
// -----------------------------------------------------------------------------
module tb_axis_pkt_arbiter;

  localparam int DW = 32;
  localparam int KW = 4;
  localparam int UW = 8;
  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic [DW-1:0] s00_tdata, s01_tdata, m00_tdata;
  logic [KW-1:0] s00_tkeep, s01_tkeep, m00_tkeep;
  logic [UW-1:0] s00_tuser, s01_tuser, m00_tuser;
  logic          s00_tlast, s01_tlast, m00_tlast;
  logic          s00_tvalid, s01_tvalid, m00_tvalid;
  logic          s00_tready, s01_tready, m_ready;
  logic [1:0]    grant;
  logic [CW-1:0] pkt_cnt0, pkt_cnt1;

  always #5 CLK = ~CLK;

  axis_pkt_arbiter #(.DATA_W(DW), .KEEP_W(KW), .USER_W(UW), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST),
    .s00_axis_tdata(s00_tdata), .s00_axis_tkeep(s00_tkeep), .s00_axis_tuser(s00_tuser),
    .s00_axis_tlast(s00_tlast), .s00_axis_tvalid(s00_tvalid), .s00_axis_tready(s00_tready),
    .s01_axis_tdata(s01_tdata), .s01_axis_tkeep(s01_tkeep), .s01_axis_tuser(s01_tuser),
    .s01_axis_tlast(s01_tlast), .s01_axis_tvalid(s01_tvalid), .s01_axis_tready(s01_tready),
    .m00_axis_tdata(m00_tdata), .m00_axis_tkeep(m00_tkeep), .m00_axis_tuser(m00_tuser),
    .m00_axis_tlast(m00_tlast), .m00_axis_tvalid(m00_tvalid), .m00_axis_tready(m_ready),
    .grant(grant), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct {
    bit send0;
    bit send1;
    bit first1;
    int exp_cnt0;
    int exp_cnt1;
  } row_t;

  beat_t      q0[$];
  beat_t      q1[$];
  beat_t      exp_q[$];
  logic [1:0] grant_seq[$];
  logic [1:0] prev_grant = 2'b00;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         stall_cnt = 0;
  int         out_cnt = 0;
  int         first_out = 0;
  int         last_out = 0;
  int         in1_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, then sample what the next posedge will see.
  task automatic step();
    beat_t e;
    @(negedge CLK);
    cyc++;
    s00_tvalid = (q0.size() != 0);
    s00_tdata  = (q0.size() != 0) ? q0[0].data : 32'h0;
    s00_tlast  = (q0.size() != 0) ? q0[0].last : 1'b0;
    s00_tuser  = s00_tdata[7:0];
    s01_tvalid = (q1.size() != 0);
    s01_tdata  = (q1.size() != 0) ? q1[0].data : 32'h0;
    s01_tlast  = (q1.size() != 0) ? q1[0].last : 1'b0;
    s01_tuser  = s01_tdata[7:0];
    m_ready    = (stall_cnt == 0);
    if (stall_cnt > 0) stall_cnt--;
    #1;
    checks++;
    if ((grant != 2'b01 && s00_tready) || (grant != 2'b10 && s01_tready) || grant == 2'b11) begin
      errors++;
      $display("FAIL tready_owner: grant=%b s00_tready=%b s01_tready=%b", grant, s00_tready, s01_tready);
    end
    if (grant != prev_grant && grant != 2'b00) grant_seq.push_back(grant);
    prev_grant = grant;
    if (s00_tvalid && s00_tready) void'(q0.pop_front());
    if (s01_tvalid && s01_tready) begin
      void'(q1.pop_front());
      in1_cnt++;
    end
    if (m00_tvalid && m_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", m00_tdata);
      end else begin
        e = exp_q.pop_front();
        if (m00_tdata !== e.data || m00_tlast !== e.last || m00_tuser !== e.data[7:0] || m00_tkeep !== 4'hF) begin
          errors++;
          $display("FAIL beat: got data 0x%0h last %b user 0x%0h keep 0x%0h expected data 0x%0h last %b",
                   m00_tdata, m00_tlast, m00_tuser, m00_tkeep, e.data, e.last);
        end
      end
      if (out_cnt == 0) first_out = cyc;
      last_out = cyc;
      out_cnt++;
    end
  endtask

  task automatic add_pkt(input int port, input int len, input int base, input bit push_exp);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = base + i;
      b.last = (i == len - 1);
      if (port == 0) q0.push_back(b);
      else q1.push_back(b);
      if (push_exp) exp_q.push_back(b);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || exp_q.size() != 0) && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL %s_timeout: pending exp=%0d in0=%0d in1=%0d, expected 0", name, exp_q.size(), q0.size(), q1.size());
      exp_q.delete(); q0.delete(); q1.delete();
    end
    repeat (3) step();
  endtask

  task automatic clear_stats();
    out_cnt = 0;
    in1_cnt = 0;
    grant_seq.delete();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    q0.delete(); q1.delete(); exp_q.delete();
    repeat (2) step();
    RST = 1'b0;
    clear_stats();
  endtask

  function automatic logic [1:0] gseq(input int i);
    return (grant_seq.size() > i) ? grant_seq[i] : 2'b00;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t tbl[7];
    int   base;
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1, 1};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1, 2};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 2, 3};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 3, 3};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 4, 4};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 4, 5};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 5, 6};

    RST = 1'b1;
    s00_tkeep = 4'hF; s01_tkeep = 4'hF;
    s00_tvalid = 1'b0; s01_tvalid = 1'b0; s00_tlast = 1'b0; s01_tlast = 1'b0;
    s00_tdata = 32'h0; s01_tdata = 32'h0; s00_tuser = 8'h0; s01_tuser = 8'h0;
    m_ready = 1'b1;
    repeat (2) step();
    chk("rst_m00_tvalid", {31'h0, m00_tvalid}, 32'h0);
    chk("rst_m00_tdata", m00_tdata, 32'h0);
    chk("rst_grant", {30'h0, grant}, 32'h0);
    chk("rst_cnt0", {28'h0, pkt_cnt0}, 32'h0);
    chk("rst_cnt1", {28'h0, pkt_cnt1}, 32'h0);
    chk("rst_treadys", {30'h0, s00_tready, s01_tready}, 32'h0);
    RST = 1'b0;

    // Round-robin table: single-beat packets, history carried row to row.
    for (int r = 0; r < 7; r++) begin
      clear_stats();
      base = 32'h1000_0000 + r * 32'h100;
      if (tbl[r].send0 && tbl[r].send1) begin
        add_pkt(tbl[r].first1 ? 1 : 0, 1, base + (tbl[r].first1 ? 32'h10 : 32'h0), 1'b1);
        add_pkt(tbl[r].first1 ? 0 : 1, 1, base + (tbl[r].first1 ? 32'h0 : 32'h10), 1'b1);
      end else if (tbl[r].send0) begin
        add_pkt(0, 1, base, 1'b1);
      end else begin
        add_pkt(1, 1, base + 32'h10, 1'b1);
      end
      drain("rr_row");
      chk("rr_first_grant", {30'h0, gseq(0)}, tbl[r].first1 ? 32'h2 : 32'h1);
      chk("rr_cnt0", {28'h0, pkt_cnt0}, tbl[r].exp_cnt0);
      chk("rr_cnt1", {28'h0, pkt_cnt1}, tbl[r].exp_cnt1);
    end

    // Both ports with 3-beat packets: s00 first, one bubble, then s01.
    do_reset();
    add_pkt(0, 3, 32'hA000_0001, 1'b1);
    add_pkt(1, 3, 32'hB000_0001, 1'b1);
    drain("both3");
    chk("both3_grant_count", grant_seq.size(), 32'd2);
    chk("both3_grant0", {30'h0, gseq(0)}, 32'h1);
    chk("both3_grant1", {30'h0, gseq(1)}, 32'h2);
    chk("both3_span", last_out - first_out, 32'd6);
    chk("both3_cnt0", {28'h0, pkt_cnt0}, 32'd1);
    chk("both3_cnt1", {28'h0, pkt_cnt1}, 32'd1);

    // s01 streaming 2-beat packets alone: one bubble between packets.
    do_reset();
    for (int p = 0; p < 3; p++) add_pkt(1, 2, 32'hB100_0000 + p * 16, 1'b1);
    drain("s01_stream");
    chk("s01_stream_span", last_out - first_out, 32'd7);
    chk("s01_stream_grants", grant_seq.size(), 32'd3);
    chk("s01_stream_cnt1", {28'h0, pkt_cnt1}, 32'd3);
    chk("s01_stream_cnt0", {28'h0, pkt_cnt0}, 32'd0);

    // Downstream stall of 4 cycles in the middle of a 5-beat packet.
    do_reset();
    add_pkt(0, 5, 32'h1, 1'b1);
    for (int n = 0; n < 40 && out_cnt < 2; n++) step();
    chk("stall_pre_beats", out_cnt, 32'd2);
    stall_cnt = 4;
    for (int n = 0; n < 4; n++) begin
      step();
      chk("stall_tvalid", {31'h0, m00_tvalid}, 32'h1);
      chk("stall_tdata", m00_tdata, 32'h3);
      chk("stall_s00_tready", {31'h0, s00_tready}, 32'h0);
    end
    drain("stall");
    chk("stall_beats", out_cnt, 32'd5);
    chk("stall_cnt0", {28'h0, pkt_cnt0}, 32'd1);

    // s00 single-beat packets against a busy s01: strict alternation.
    do_reset();
    for (int p = 0; p < 3; p++) begin
      add_pkt(0, 1, 32'hA200_0000 + p, 1'b1);
      add_pkt(1, 1, 32'hB200_0000 + p, 1'b1);
    end
    drain("alt");
    chk("alt_grants", grant_seq.size(), 32'd6);
    chk("alt_cnt0", {28'h0, pkt_cnt0}, 32'd3);
    chk("alt_cnt1", {28'h0, pkt_cnt1}, 32'd3);

    // Reset during beat 2 of a 4-beat s01 packet.
    do_reset();
    add_pkt(1, 1, 32'hB300_0000, 1'b1);
    drain("pre_rst");
    chk("pre_rst_cnt1", {28'h0, pkt_cnt1}, 32'd1);
    clear_stats();
    add_pkt(1, 4, 32'hB400_0000, 1'b0);
    for (int n = 0; n < 40 && in1_cnt < 1; n++) step();
    chk("mid_rst_beat1_taken", in1_cnt, 32'd1);
    @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    chk("mid_rst_m00_tvalid", {31'h0, m00_tvalid}, 32'h0);
    chk("mid_rst_m00_tdata", m00_tdata, 32'h0);
    chk("mid_rst_m00_tlast", {31'h0, m00_tlast}, 32'h0);
    chk("mid_rst_grant", {30'h0, grant}, 32'h0);
    chk("mid_rst_cnt1", {28'h0, pkt_cnt1}, 32'h0);
    chk("mid_rst_treadys", {30'h0, s00_tready, s01_tready}, 32'h0);
    do_reset();
    add_pkt(0, 1, 32'hA500_0000, 1'b1);
    add_pkt(1, 1, 32'hB500_0000, 1'b1);
    drain("post_rst");
    chk("post_rst_first_grant", {30'h0, gseq(0)}, 32'h1);

    // Counter wrap with 4-bit counters: 15 -> 0 -> 1.
    do_reset();
    for (int p = 0; p < 15; p++) add_pkt(0, 1, 32'hA600_0000 + p, 1'b1);
    drain("wrap_fill");
    chk("wrap_cnt0_15", {28'h0, pkt_cnt0}, 32'd15);
    add_pkt(0, 1, 32'hA600_0100, 1'b1);
    drain("wrap_a");
    chk("wrap_cnt0_0", {28'h0, pkt_cnt0}, 32'd0);
    add_pkt(0, 1, 32'hA600_0200, 1'b1);
    drain("wrap_b");
    chk("wrap_cnt0_1", {28'h0, pkt_cnt0}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
